// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding, default
// line constants and the clken divider computation.
package uart_pkg;

    typedef enum logic [1:0] {
        RXC_IDLE      = 2'd0,
        RXC_CLEAR     = 2'd1,
        RXC_WAIT_DROP = 2'd2
    } rxc_state_e;

    localparam int unsigned UART_CLK_HZ = 50000000;
    localparam int unsigned UART_BAUD   = 115200;

    // 16x oversampling: one clken per sixteenth of a bit time
    function automatic int unsigned uart_calc_div(input int unsigned clk_hz,
                                                  input int unsigned baud);
        return clk_hz / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular synchronous FIFO with registered first-word-fall-through head.
// The head register holds its last value while the FIFO is empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = rdata_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rdata_d = rdata_q;
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for the 16x UART receiver: clken divider, byte-drain FSM, byte FIFO.
// Define UART_RX_TIMEOUT_EN to add the rx_timeout idle-data indication.
//
//  state         | meaning
//  RXC_IDLE      | waiting for rdy; captures the byte and raises rdy_clr
//  RXC_CLEAR     | rdy_clr pulse cycle, receiver is dropping rdy
//  RXC_WAIT_DROP | waits for rdy low so each byte is captured exactly once
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = UART_CLK_HZ,
    parameter int unsigned BAUD   = UART_BAUD,
    parameter int unsigned DIV    = uart_calc_div(CLK_HZ, BAUD),
    parameter int unsigned DEPTH  = 4
`ifdef UART_RX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_TICKS = 64
`endif
) (
    input  logic                   clk_50m,
    input  logic                   rst_n,
    input  logic                   rx_en,
    output logic                   rx_clken,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   rx_rdy_clr,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overrun,
    input  logic                   overrun_clr
`ifdef UART_RX_TIMEOUT_EN
    ,
    output logic                   rx_timeout
`endif
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic [15:0] div_cnt_q, div_cnt_d;
    logic        clken_q;
    rxc_state_e  state_q;
    logic        rdy_clr_q;
    logic        overrun_q;
    logic        push_req, pop_req, fifo_full, fifo_empty, drop;

    assign push_req = rx_en & rx_rdy & (state_q == RXC_IDLE);
    assign pop_req  = m_ready & ~fifo_empty;
    assign drop     = push_req & fifo_full & ~pop_req;

    assign rx_clken   = clken_q;
    assign rx_rdy_clr = rdy_clr_q;
    assign m_valid    = ~fifo_empty;
    assign overrun    = overrun_q;

    always_comb begin
        div_cnt_d = '0;
        if (rx_en && (div_cnt_q != DIV_LAST)) begin
            div_cnt_d = div_cnt_q + 16'd1;
        end
    end

    // clken decodes the next count so it is high exactly while count == DIV-1
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            clken_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clken_q   <= (div_cnt_d == DIV_LAST);
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RXC_IDLE;
            rdy_clr_q <= 1'b0;
        end else if (!rx_en) begin
            state_q   <= RXC_IDLE;
            rdy_clr_q <= 1'b0;
        end else begin
            rdy_clr_q <= 1'b0;
            unique case (state_q)
                RXC_IDLE: begin
                    if (rx_rdy) begin
                        state_q   <= RXC_CLEAR;
                        rdy_clr_q <= 1'b1;
                    end
                end
                RXC_CLEAR: state_q <= RXC_WAIT_DROP;
                RXC_WAIT_DROP: begin
                    if (!rx_rdy) begin
                        state_q <= RXC_IDLE;
                    end
                end
                default: state_q <= RXC_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_50m),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (m_ready),
        .wdata_i (rx_data),
        .rdata_o (m_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef UART_RX_TIMEOUT_EN
    logic [7:0] tick_q;
    logic       push_ok, going_empty;

    assign push_ok     = push_req & (~fifo_full | pop_req);
    assign going_empty = ~push_ok &
                         (fifo_empty | ((fifo_count == ($clog2(DEPTH)+1)'(1)) & pop_req));
    assign rx_timeout  = (tick_q >= 8'(TIMEOUT_TICKS));

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (push_ok || going_empty) begin
            tick_q <= '0;
        end else if (clken_q && (tick_q != 8'hFF)) begin
            tick_q <= tick_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DIV=27, DEPTH=4).
// Covers the timeout indication when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_ctrl;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       rx_en;
    logic       rx_clken;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy_clr;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       overrun_clr;
`ifdef UART_RX_TIMEOUT_EN
    logic       rx_timeout;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk_50m = ~clk_50m;

    uart_rx_ctrl #(.DEPTH(4)) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .rx_en       (rx_en),
        .rx_clken    (rx_clken),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .rx_rdy_clr  (rx_rdy_clr),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef UART_RX_TIMEOUT_EN
        ,
        .rx_timeout  (rx_timeout)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    // One full receiver handshake: rdy for one cycle, then CLEAR and WAIT_DROP
    task automatic capture(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        step();
        rx_rdy  = 1'b0;
        step();
        step();
    endtask

    logic [7:0] exp_q [4];
    int         pulses;

    initial begin
        rst_n = 1'b0; rx_en = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
        m_ready = 1'b0; overrun_clr = 1'b0;
        step();
        step();
        chk("rst_clken",   32'(rx_clken),   0);
        chk("rst_rdy_clr", 32'(rx_rdy_clr), 0);
        chk("rst_m_valid", 32'(m_valid),    0);
        chk("rst_m_data",  32'(m_data),     0);
        chk("rst_count",   32'(fifo_count), 0);
        chk("rst_overrun", 32'(overrun),    0);
        rst_n = 1'b1;

        // divider: pulses after 26, 53 and 80 enabled edges
        rx_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            chk($sformatf("div_c%0d", i), 32'(rx_clken), 32'((i % 27) == 26));
        end
        rx_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rx_clken) pulses++;
        end
        chk("div_off_pulses", 32'(pulses), 0);
        rx_en = 1'b1;
        for (int i = 1; i <= 27; i++) begin
            step();
            chk($sformatf("div_restart_c%0d", i), 32'(rx_clken), 32'(i == 26));
        end

        // single byte, rdy held high for 3 extra cycles
        rx_data = 8'hA5;
        rx_rdy  = 1'b1;
        step();
        chk("sb_rdy_clr", 32'(rx_rdy_clr), 1);
        chk("sb_m_valid", 32'(m_valid),    1);
        chk("sb_m_data",  32'(m_data),     32'h A5);
        chk("sb_count",   32'(fifo_count), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sb_hold_clr%0d", i), 32'(rx_rdy_clr), 0);
            chk($sformatf("sb_hold_cnt%0d", i), 32'(fifo_count), 1);
        end
        rx_rdy = 1'b0;
        step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("sb_pop_count", 32'(fifo_count), 0);
        chk("sb_pop_valid", 32'(m_valid),    0);
        chk("sb_pop_hold",  32'(m_data),     32'h A5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("empty_ready_ignored", 32'(fifo_count), 0);

        // fill to DEPTH, fifth byte dropped
        for (int i = 1; i <= 4; i++) capture(8'(i));
        chk("fill_count",      32'(fifo_count), 4);
        chk("fill_no_overrun", 32'(overrun),    0);
        capture(8'h05);
        chk("ovr_count", 32'(fifo_count), 4);
        chk("ovr_set",   32'(overrun),    1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_pop%0d", i), 32'(m_data), 32'(i));
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
        end
        chk("ovr_drained", 32'(fifo_count), 0);
        chk("ovr_sticky",  32'(overrun),    1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);

        // full FIFO with simultaneous capture and pop
        for (int i = 0; i < 4; i++) capture(8'h10 + 8'(i));
        chk("fs_full", 32'(fifo_count), 4);
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        m_ready = 1'b1;
        step();
        rx_rdy  = 1'b0;
        m_ready = 1'b0;
        chk("fs_no_overrun", 32'(overrun),    0);
        chk("fs_count",      32'(fifo_count), 4);
        chk("fs_head",       32'(m_data),     32'h11);
        step();
        step();
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h77};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fs_pop%0d", i), 32'(m_data), 32'(exp_q[i]));
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
        end
        chk("fs_empty", 32'(m_valid), 0);

        // async reset while in WAIT_DROP with two bytes buffered
        capture(8'h21);
        rx_data = 8'h22;
        rx_rdy  = 1'b1;
        step();
        step();
        chk("ar_pre_count", 32'(fifo_count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count",   32'(fifo_count), 0);
        chk("ar_valid",   32'(m_valid),    0);
        chk("ar_data",    32'(m_data),     0);
        chk("ar_rdy_clr", 32'(rx_rdy_clr), 0);
        chk("ar_clken",   32'(rx_clken),   0);
        chk("ar_overrun", 32'(overrun),    0);
        rx_rdy = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        rx_data = 8'h33;
        rx_rdy  = 1'b1;
        step();
        rx_rdy  = 1'b0;
        chk("ar_next_clr",   32'(rx_rdy_clr), 1);
        chk("ar_next_data",  32'(m_data),     32'h33);
        chk("ar_next_count", 32'(fifo_count), 1);
        step();
        step();

`ifdef UART_RX_TIMEOUT_EN
        // one byte buffered: timeout after 64 clken ticks, cleared by the pop
        pulses = 0;
        for (int i = 0; i < 64 * 27 + 200 && pulses < 64; i++) begin
            step();
            if (rx_clken) pulses++;
        end
        chk("to_pulses", 32'(pulses), 64);
        chk("to_before", 32'(rx_timeout), 0);
        step();
        chk("to_set", 32'(rx_timeout), 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("to_clear", 32'(rx_timeout), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller that sequences the 16x-oversampling UART receiver.
- Generates the receiver's `clken` sample strobe from the 50 MHz clock.
- Drains each completed byte: watches `rdy`, captures `data`, pulses `rdy_clr`.
- Buffers bytes in a small FIFO and presents them on a valid/ready stream, with sticky overrun reporting.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line baud rate.
- DIV, CLK_HZ/(BAUD*16) (=27), clken period in clocks; legal range 2..65535.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk_50m  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_en  input  1  enables strobe generation and byte draining.
- rx_clken  output  1  one-cycle sample strobe to the receiver `clken`.
- rx_rdy  input  1  receiver `rdy`.
- rx_data  input  8  receiver `data`, valid while rx_rdy=1.
- rx_rdy_clr  output  1  one-cycle pulse to the receiver `rdy_clr`.
- m_data  output  8  FIFO head byte.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  consumer accepts the head byte when m_valid&m_ready.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (rst_n=0, async): rx_clken=0, rx_rdy_clr=0, m_valid=0, m_data=0, fifo_count=0, overrun=0, divider=0, FSM=IDLE, pointers=0.
  - Reset mid-byte discards FIFO contents.
- Divider:
  - Counts 0..DIV-1 while rx_en=1; rx_clken=1 exactly in the cycle count==DIV-1, then wraps to 0.
  - rx_en=0 holds the counter at 0 and rx_clken=0.
  - Period is exactly DIV clocks, with no drift across wrap.
- FSM states: IDLE, CLEAR, WAIT_DROP; all outputs registered.
  - IDLE: if rx_en&rx_rdy in cycle T:
    - Write rx_data to FIFO at the end of T; if the FIFO is full and there is no simultaneous pop, drop the byte and set overrun.
    - Set rx_rdy_clr=1 for cycle T+1; go to CLEAR.
  - CLEAR: rx_rdy_clr returns to 0; go to WAIT_DROP.
  - WAIT_DROP: stay while rx_rdy=1; go to IDLE on rx_rdy=0. This guarantees one capture per byte.
  - rx_en=0 in any state: return to IDLE next cycle, no capture. Buffered bytes remain poppable.
- Latency: rx_rdy rising in cycle T gives m_valid=1 and m_data=byte in T+1 (empty FIFO case).
- FIFO:
  - Circular, with $clog2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - fifo_count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop.
  - When full, push and pop in the same cycle: both succeed, no overrun.
  - When empty, m_ready is ignored; m_data holds its last value.
  - m_data is always the entry at the read pointer, registered (first-word fall-through).
- Overrun: set has priority over overrun_clr when both occur in the same cycle.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_TICKS (default 64, i.e. 4 bit-times) and output rx_timeout (1 bit).
  - An 8-bit tick counter increments on rx_clken while the FIFO is non-empty; it is zeroed on every push or when the FIFO is empty.
  - rx_timeout=1 (level) once the counter reaches TIMEOUT_TICKS; it holds until the next push or until the FIFO empties. The counter saturates.
- Undefined: no port, no counter; behaviour otherwise identical.

Decomposition:
- Package uart_pkg: FSM state encoding (RXC_IDLE, RXC_CLEAR, RXC_WAIT_DROP), default CLK_HZ/BAUD constants, and a DIV computation function.
- One sub-module: uart_sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty/count), instantiated for the byte buffer.
- Divider and FSM live in uart_rx_ctrl.

Test Plan:
- Divider: DIV=27, rx_en=1 for 100 cycles -> rx_clken pulses at cycles 26, 53, 80, each 1 cycle wide; rx_en dropped -> no further pulses, counter restarts at 0.
- Single byte: rx_rdy=1 with rx_data=0xA5 held until rdy_clr -> exactly one rx_rdy_clr pulse one cycle after; m_valid=1, m_data=0xA5, fifo_count=1; one capture only even if rx_rdy stays high 3 extra cycles.
- Fill/overrun: push 0x01..0x05 with m_ready=0, DEPTH=4 -> fifo_count=4, overrun=1 after the 5th; pops yield 0x01..0x04; overrun_clr -> overrun=0.
- Full + simultaneous: FIFO full, m_ready=1 in the same cycle as a capture of 0x77 -> no overrun, count stays 4, 0x77 is the last out.
- Async reset mid-operation: assert rst_n=0 between the capture and the WAIT_DROP exit with count=2 -> all outputs 0 immediately; after release FSM=IDLE and the next byte is captured normally.
- UART_RX_TIMEOUT_EN: 1 byte buffered, no m_ready, 64 rx_clken ticks -> rx_timeout=1; a pop empties the FIFO -> rx_timeout=0 next cycle.
